// File: rtl/de2_key_event_ctrl.sv
// DE2 push-button PIO sequencer: programs the IRQ mask, services edge-capture
// interrupts and turns each captured key into an event in a small FIFO.
module de2_key_event_ctrl #(
    parameter int KEY_WIDTH      = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int HOLDOFF_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          pio_irq,
    input  logic [31:0]                   pio_readdata,
    output logic [1:0]                    pio_address,
    output logic                          pio_chipselect,
    output logic                          pio_write_n,
    output logic [31:0]                   pio_writedata,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [2:0]                    evt_key,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          busy
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int HW    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int HLOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        INIT_MASK, INIT_CLR, IDLE, RD, RD_WAIT, CLR, SPLIT, HOLDOFF
    } state_t;

    state_t               state, next;
    logic [KEY_WIDTH-1:0] pending, pending_rest;
    logic [2:0]           low_idx;
    logic [PW-1:0]        wptr, rptr;
    logic [2:0]           mem [FIFO_DEPTH];
    logic [HW-1:0]        hcnt;
    logic                 push, drop, pop, full;
    logic                 unused_rd;

    assign unused_rd = ^pio_readdata;

    // pending with its lowest set bit removed
    assign pending_rest = pending & (pending - KEY_WIDTH'(1));

    always_comb begin
        low_idx = '0;
        for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= INIT_MASK;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            INIT_MASK: next = INIT_CLR;
            INIT_CLR:  next = IDLE;
            IDLE:      if (pio_irq && enable) next = RD;
            RD:        next = RD_WAIT;
            RD_WAIT:   next = CLR;
            CLR:       next = SPLIT;
            SPLIT: begin
                if (pending_rest == '0)
                    next = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            end
            HOLDOFF:   if (hcnt == '0) next = IDLE;
            default:   next = INIT_MASK;
        endcase
    end

    always_comb begin
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = 2'd0;
        pio_writedata  = '0;
        busy           = 1'b1;
        if (!reset) begin
            case (state)
                INIT_MASK: begin
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_address    = 2'd2;
                    pio_writedata[KEY_WIDTH-1:0] = '1;
                end
                INIT_CLR, CLR: begin
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_address    = 2'd3;
                end
                RD, RD_WAIT: begin
                    pio_chipselect = 1'b1;
                    pio_address    = 2'd3;
                end
                IDLE:    busy = 1'b0;
                default: ;
            endcase
        end
    end

    assign full      = (evt_count == DEPTH_C);
    assign push      = (state == SPLIT) && (pending != '0) && !full;
    assign drop      = (state == SPLIT) && (pending != '0) && full;
    assign evt_valid = (evt_count != '0);
    assign pop       = evt_valid && evt_ready;
    assign evt_key   = evt_valid ? mem[rptr] : 3'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else if (state == RD_WAIT) begin
            pending <= pio_readdata[KEY_WIDTH-1:0];
        end else if (state == SPLIT) begin
            pending <= pending_rest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
        end else if (state == SPLIT && next == HOLDOFF) begin
            hcnt <= HW'(HLOAD);
        end else if (state == HOLDOFF && hcnt != '0) begin
            hcnt <= hcnt - HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= low_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            evt_count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            evt_count <= evt_count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (reset)             overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

endmodule

// File: doc/de2_key_event_ctrl.md
# de2_key_event_ctrl

Controller that owns the 4-bit DE2 push-button PIO and sequences it on behalf of software-free consumers. After reset it programs the PIO interrupt mask and clears its edge-capture register. On each PIO interrupt it reads edge-capture, clears it, and splits the captured bits into one key-index event per pressed key in a small FIFO. A hold-off counter suppresses switch-bounce re-triggers. It sits between the key PIO's Avalon slave port and any hardware consumer of key presses.

## Interface

- KEY_WIDTH, 4: number of keys, i.e. PIO data width; 1..8.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- HOLDOFF_CYCLES, 50000: idle cycles after each service before `pio_irq` is sampled again; 0 disables the hold-off.
- clk  in  1  system clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = service interrupts; 0 = stay in IDLE (a service already in progress completes).
- pio_irq  in  1  PIO interrupt (edge_capture & irq_mask nonzero).
- pio_readdata  in  32  PIO read data; registered in the PIO, valid the cycle after the address is presented.
- pio_address  out  2  PIO register select: 2 = irq mask, 3 = edge capture.
- pio_chipselect  out  1  PIO chip select.
- pio_write_n  out  1  active-low PIO write strobe.
- pio_writedata  out  32  PIO write data.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accept; a pop happens when evt_valid && evt_ready.
- evt_key  out  3  key index at the FIFO head (0..KEY_WIDTH-1).
- evt_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- overflow_clr  in  1  clears `overflow`; if a drop occurs in the same cycle, the drop wins and `overflow` stays 1.
- busy  out  1  1 in every state except IDLE.

## Operation

- States: INIT_MASK, INIT_CLR, IDLE, RD, RD_WAIT, CLR, SPLIT, HOLDOFF. Reset state is INIT_MASK.
- Bus idle value: chipselect=0, write_n=1, address=0, writedata=0. Bus outputs are decoded from the state and forced to the idle value while reset=1.
- INIT_MASK: write address 2, data = KEY_WIDTH ones, zero-extended. Next state INIT_CLR.
- INIT_CLR: write address 3, data 0. Next state IDLE.
- IDLE: go to RD if pio_irq && enable; otherwise stay.
- RD: chipselect=1, write_n=1, address=3. Next state RD_WAIT.
- RD_WAIT: drive the same values as RD. Latch `pending` = pio_readdata[KEY_WIDTH-1:0]. Next state CLR.
- CLR: write address 3 (clears all capture bits). Next state SPLIT.
- SPLIT:
  - Each cycle, take the lowest set bit of `pending`.
  - If FIFO count < FIFO_DEPTH, push its index; otherwise drop it and set `overflow`. Clear the bit either way.
  - Leave to HOLDOFF (or IDLE when HOLDOFF_CYCLES=0) in the cycle `pending` becomes zero. If `pending` was 0 on entry, leave after one cycle.
- HOLDOFF: load the counter with HOLDOFF_CYCLES-1 on entry and decrement it. Go to IDLE in the cycle the counter reads 0.
- Full test uses the current count only: a push while full is dropped even if a pop occurs in the same cycle.
- Pushing and popping in the same cycle when not full leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- An edge captured by the PIO after the RD sample and before CLR is lost. This is accepted; the window is 2 cycles.
- Reset asserted mid-operation:
  - Abandons any bus access.
  - Empties the FIFO and clears `overflow` and `pending`.
  - Reruns INIT_MASK and INIT_CLR.

## Timing

- Reset values: evt_valid=0, evt_key=0, evt_count=0, overflow=0, busy=1 (state is INIT_MASK); bus outputs at the idle value.
- First cycle with reset=0 is the INIT_MASK write; the next cycle is INIT_CLR; IDLE follows.
- pio_irq high in IDLE at cycle T gives: RD at T+1, RD_WAIT at T+2, CLR at T+3, first SPLIT at T+4.
- First evt_valid=1 at T+5 (FIFO write is registered; the head appears the cycle after the push).
- N set bits take max(N,1) SPLIT cycles. HOLDOFF then lasts exactly HOLDOFF_CYCLES cycles.
- FIFO output is first-word-fall-through: evt_key is valid whenever evt_valid=1. A pop is reflected in the next cycle.

## Test plan

- Reset release: the first two cycles show a write of 0x0000000F to address 2, then a write of 0x00000000 to address 3; busy falls on cycle 3.
- Single key (HOLDOFF_CYCLES=4): pio_irq at T with readdata=0x2.
  - Expect read of address 3 at T+1..T+2, then clear-write at T+3.
  - Expect evt_valid at T+5 with evt_key=1, busy low at T+9.
- Multiple keys: readdata=0xD with evt_ready=1 → events 0, 2, 3 in that order on consecutive cycles; evt_count never exceeds 1.
- Overflow (FIFO_DEPTH=2, evt_ready=0): readdata=0xF → events 0 and 1 stored, events 2 and 3 dropped, overflow=1. An overflow_clr pulse then clears it.
- Hold-off and enable:
  - pio_irq held high during HOLDOFF → no bus activity until HOLDOFF ends.
  - With enable=0, pio_irq never leaves IDLE.
- Mid-service reset: assert reset in SPLIT with 2 events queued → evt_count=0 and overflow=0, and the init writes are repeated after release.
